instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter READ_LATENCY, default 40: clock edges from request acceptance to data valid; legal range 1..255.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 read  input  1  block read request from the instruction cache; held high until busywait is seen low.
REQ-005 address  input  6  block address {tag[2:0], index[2:0]}; 64 blocks of 16 bytes (1024 bytes total).
REQ-006 readdata  output  128  fetched block; word w occupies bits [32w+31:32w], w = byte address [3:2].
REQ-007 busywait  output  1  high while a request is pending or in flight.
REQ-008 load_en  input  1  preload strobe, one 32-bit word per edge.
REQ-009 load_addr  input  8  preload word address; block = [7:2], word = [1:0].
REQ-010 load_data  input  32  preload word value.

Function
REQ-011 The block SHALL implement the FSM states IDLE, READING and COMPLETE.
REQ-012 busywait SHALL be combinational: 1 when (state==IDLE and read==1) or state==READING; 0 otherwise, including throughout COMPLETE.
REQ-013 IDLE with read==1 at an edge (the acceptance edge N) SHALL latch address, load the counter with READ_LATENCY-1 and enter READING.
REQ-014 READING SHALL decrement the counter each edge. At the edge where the counter is already 0 (edge N+READ_LATENCY), it SHALL register the addressed block into readdata and enter COMPLETE.
REQ-015 COMPLETE SHALL last exactly one cycle, with busywait=0 and readdata valid, then return to IDLE regardless of read.
REQ-016 A read still high in the cycle after COMPLETE SHALL be treated as a new request.
REQ-017 Changes on address during READING or COMPLETE SHALL be ignored; the latched address is used.
REQ-018 readdata SHALL hold its last value until the next COMPLETE entry and SHALL never change outside that edge.
REQ-019 load_en SHALL write load_data into the addressed word only when state==IDLE and read==0; otherwise it is ignored with no side effect.
REQ-020 If a load and a completing read target the same block, the read SHALL return pre-load contents; ordering is defined by REQ-019.
REQ-021 Memory contents SHALL be word-granular, and each load SHALL leave the other three words of the block unchanged.

Reset
REQ-022 When reset==1 at an edge, state SHALL become IDLE, the counter 0 and readdata 0, and any in-flight read SHALL be aborted without updating readdata.
REQ-023 Memory array contents SHALL NOT be altered by reset.
REQ-024 After reset deasserts, a still-high read SHALL raise busywait combinationally and be accepted at the next edge per REQ-013.
REQ-025 Reset SHALL take priority over read and load_en on the same edge.

Structure
REQ-026 A shared package SHALL hold WORD_W=32, BLOCK_W=128, BLOCK_ADDR_W=6, WORD_ADDR_W=8, NUM_BLOCKS=64 and the FSM state enum; the instruction cache SHALL import the same package.
REQ-027 The latency countdown SHALL be a sub-module imem_latency_counter with inputs load, value[7:0], enable and output zero.
REQ-028 The storage SHALL be one array of 64 x 128-bit entries with a single read port and a word-enabled write port.

Verification
REQ-029 Basic read: preload block 5 with words 0x11111111/0x22222222/0x33333333/0x44444444 (w0..w3), assert read with address=5 -> busywait high immediately, low in exactly the cycle after edge N+40, readdata=0x44444444_33333333_22222222_11111111.
REQ-030 Latency boundary: READ_LATENCY=1 on block 0 -> COMPLETE entered at edge N+1; busywait high for exactly 2 cycles in total.
REQ-031 Address instability: change address from 5 to 9 two cycles after acceptance -> readdata equals block 5 contents.
REQ-032 Back-to-back reads: hold read high through COMPLETE with address changed to 63 -> one-cycle busywait low, then a second request accepted; readdata shows block 63 after another 40 edges.
REQ-033 Reset mid-read: assert reset at edge N+20 -> state IDLE, readdata=0 and block contents intact; a re-issued read returns the correct data after 40 edges.
REQ-034 Load gating: pulse load_en (addr 0x14, data 0xDEADBEEF) during READING -> ignored; repeat in IDLE with read=0 -> a later read of block 5 returns w0=0xDEADBEEF.

Source files
------------

// File: rtl/instruction_memory_pkg.sv
// Shared definitions for the instruction memory and the instruction cache that talks to it.
package instruction_memory_pkg;

  localparam int WORD_W       = 32;
  localparam int BLOCK_W      = 128;
  localparam int BLOCK_ADDR_W = 6;
  localparam int WORD_ADDR_W  = 8;
  localparam int NUM_BLOCKS   = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READING  = 2'd1,
    COMPLETE = 2'd2
  } imem_state_e;

endpackage

// File: rtl/instruction_memory_if.sv
// Block-read bus between the instruction cache (master) and the instruction memory (slave).
interface instruction_memory_if;
  import instruction_memory_pkg::*;

  logic                    read;
  logic [BLOCK_ADDR_W-1:0] address;
  logic [BLOCK_W-1:0]      readdata;
  logic                    busywait;

  modport master (output read, output address, input readdata, input busywait);
  modport slave  (input read, input address, output readdata, output busywait);

endinterface

// File: rtl/imem_latency_counter.sv
// Down-counter for the memory access latency; zero flags the terminal count.
module imem_latency_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       enable,
  output logic       zero
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (enable && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 8'd0);

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory: 64 blocks of 128 bits, fixed-latency block reads, word-granular preload port.
//
//   state    | meaning
//   IDLE     | waiting for a read; preload writes allowed when read is low
//   READING  | latency countdown running on the latched block address
//   COMPLETE | readdata valid, busywait low for one cycle
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int READ_LATENCY = 40
) (
  input  logic                   clock,
  input  logic                   reset,
  instruction_memory_if.slave    bus,
  input  logic                   load_en,
  input  logic [WORD_ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0]      load_data
);

  localparam logic [7:0] LAT_LOAD = 8'(READ_LATENCY - 1);

  imem_state_e             state_q, state_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic [BLOCK_W-1:0]      readdata_q, readdata_d;
  logic                    busy;
  logic                    cnt_load, cnt_en, cnt_zero;
  logic                    wr_en;

  logic [BLOCK_W-1:0]      mem_q [NUM_BLOCKS];

  imem_latency_counter u_latency (
    .clock  (clock),
    .reset  (reset),
    .load   (cnt_load),
    .value  (LAT_LOAD),
    .enable (cnt_en),
    .zero   (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    readdata_d = readdata_q;
    busy       = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.read) begin
          busy     = 1'b1;
          addr_d   = bus.address;
          cnt_load = 1'b1;
          state_d  = READING;
        end
      end
      READING: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (cnt_zero) begin
          readdata_d = mem_q[addr_q];
          state_d    = COMPLETE;
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      readdata_q <= readdata_d;
    end
  end

  // Preload only while the read port is quiet, so a completing read never sees a half-written block.
  assign wr_en = load_en && (state_q == IDLE) && !bus.read && !reset;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[load_addr[7:2]][{load_addr[1:0], 5'b00000} +: WORD_W] <= load_data;
    end
  end

  assign bus.busywait = busy;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: table vectors, directed corner cases, random reads vs a word-array model.
module tb_instruction_memory;

  localparam int LAT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_en, load1_en;
  logic [7:0]  load_addr, load1_addr;
  logic [31:0] load_data, load1_data;

  instruction_memory_if bus0();
  instruction_memory_if bus1();

  instruction_memory #(.READ_LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus0),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  instruction_memory #(.READ_LATENCY(1)) dut_l1 (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus1),
    .load_en   (load1_en),
    .load_addr (load1_addr),
    .load_data (load1_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]   addr;
    logic [127:0] data;
  } vec_t;

  vec_t         vecs [4];
  logic [31:0]  mdl [64][4];
  logic [127:0] last_rd;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] blk(input int b);
    return {mdl[b][3], mdl[b][2], mdl[b][1], mdl[b][0]};
  endfunction

  // Only called with the DUT idle and read low, where a load must take effect.
  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
    mdl[int'(a[7:2])][int'(a[1:0])] = d;
  endtask

  // Caller has raised read in IDLE; counts edges from acceptance until busywait drops.
  task automatic wait_done(input logic [127:0] exp, input int chg_at, input logic [5:0] chg_addr,
                           input bit keep, input string nm);
    int cyc;
    bit hold_ok;
    check({nm, "_busy_on"}, 128'(bus0.busywait), 128'(1));
    tick();
    cyc     = 0;
    hold_ok = 1'b1;
    while (bus0.busywait && cyc < 400) begin
      if (cyc == 1) load_en = 1'b0;
      if (cyc == chg_at) bus0.address = chg_addr;
      if (bus0.readdata !== last_rd) hold_ok = 1'b0;
      tick();
      cyc++;
    end
    check({nm, "_latency"}, 128'(cyc), 128'(LAT));
    check({nm, "_hold"}, 128'(hold_ok), 128'(1));
    check({nm, "_data"}, bus0.readdata, exp);
    last_rd = exp;
    if (!keep) begin
      bus0.read = 1'b0;
      tick();
      check({nm, "_idle"}, 128'(bus0.busywait), 128'(0));
    end
  endtask

  task automatic do_read(input int b, input string nm);
    bus0.address = 6'(b);
    bus0.read    = 1'b1;
    #1;
    wait_done(blk(b), -1, 6'd0, 1'b0, nm);
  endtask

  initial begin
    reset        = 1'b1;
    bus0.read    = 1'b0;
    bus0.address = '0;
    bus1.read    = 1'b0;
    bus1.address = '0;
    load_en      = 1'b0;
    load_addr    = '0;
    load_data    = '0;
    load1_en     = 1'b0;
    load1_addr   = '0;
    load1_data   = '0;
    last_rd      = '0;

    vecs[0] = '{addr: 6'd5,  data: 128'h44444444_33333333_22222222_11111111};
    vecs[1] = '{addr: 6'd63, data: 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0};
    vecs[2] = '{addr: 6'd0,  data: 128'h00000000_FFFFFFFF_A5A5A5A5_5A5A5A5A};
    vecs[3] = '{addr: 6'd9,  data: 128'h99999999_88888888_77777777_66666666};

    tick();
    tick();
    check("rst_readdata", bus0.readdata, 128'h0);
    check("rst_busy", 128'(bus0.busywait), 128'(0));
    check("rst_readdata_l1", bus1.readdata, 128'h0);
    reset = 1'b0;

    for (int a = 0; a < 256; a++) load_word(8'(a), $urandom());

    // Latency-1 instance: busywait high for exactly two cycles.
    for (int w = 0; w < 4; w++) begin
      load1_en   = 1'b1;
      load1_addr = 8'(w);
      load1_data = 32'hA0000000 | 32'(w);
      tick();
    end
    load1_en     = 1'b0;
    bus1.address = 6'd0;
    bus1.read    = 1'b1;
    #1;
    check("l1_busy_idle", 128'(bus1.busywait), 128'(1));
    tick();
    check("l1_busy_reading", 128'(bus1.busywait), 128'(1));
    tick();
    check("l1_busy_complete", 128'(bus1.busywait), 128'(0));
    check("l1_data", bus1.readdata, 128'hA0000003_A0000002_A0000001_A0000000);
    bus1.read = 1'b0;
    tick();
    check("l1_idle", 128'(bus1.busywait), 128'(0));

    for (int i = 0; i < 4; i++)
      for (int w = 0; w < 4; w++)
        load_word({vecs[i].addr, 2'(w)}, vecs[i].data[w*32 +: 32]);
    for (int i = 0; i < 4; i++) begin
      bus0.address = vecs[i].addr;
      bus0.read    = 1'b1;
      #1;
      wait_done(vecs[i].data, -1, 6'd0, 1'b0, $sformatf("vec%0d", i));
    end

    // Address moves from 5 to 9 two cycles after acceptance.
    bus0.address = 6'd5;
    bus0.read    = 1'b1;
    #1;
    wait_done(blk(5), 2, 6'd9, 1'b0, "addr_change");

    // Back-to-back: read held through COMPLETE, address switched to 63.
    bus0.address = 6'd5;
    bus0.read    = 1'b1;
    #1;
    wait_done(blk(5), -1, 6'd0, 1'b1, "b2b_first");
    bus0.address = 6'd63;
    #1;
    check("b2b_complete_busy", 128'(bus0.busywait), 128'(0));
    tick();
    wait_done(blk(63), -1, 6'd0, 1'b0, "b2b_second");

    // Reset at edge N+20 with read still high.
    bus0.address = 6'd63;
    bus0.read    = 1'b1;
    #1;
    tick();
    repeat (19) tick();
    bus0.address = 6'd5;
    reset = 1'b1;
    tick();
    check("midrst_readdata", bus0.readdata, 128'h0);
    check("midrst_busy", 128'(bus0.busywait), 128'(1));
    reset   = 1'b0;
    last_rd = '0;
    #1;
    wait_done(blk(5), -1, 6'd0, 1'b0, "midrst_reissue");

    // Load presented with read high (acceptance and READING edges) must be dropped.
    bus0.address = 6'd7;
    bus0.read    = 1'b1;
    load_en      = 1'b1;
    load_addr    = 8'h14;
    load_data    = 32'hDEADBEEF;
    #1;
    wait_done(blk(7), -1, 6'd0, 1'b0, "gate_busy_read");
    do_read(5, "gate_unchanged");
    check("gate_w0_old", 128'(bus0.readdata[31:0]), 128'(32'h11111111));
    load_word(8'h14, 32'hDEADBEEF);
    do_read(5, "gate_loaded");
    check("gate_w0_new", 128'(bus0.readdata[31:0]), 128'(32'hDEADBEEF));
    check("gate_w1_kept", 128'(bus0.readdata[63:32]), 128'(32'h22222222));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        load_word(8'($urandom_range(0, 255)), $urandom());
      end else begin
        do_read(int'($urandom_range(0, 63)), $sformatf("rand%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
